// File: rtl/ms_arbiter_if.sv
// Requester bus and multiplier handshake shared between ms_arbiter and its neighbours.
// Signal names keep their i_/o_ direction as seen from the arbiter.
interface ms_arbiter_if #(
    parameter int DW   = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    i_req;
    logic [NREQ*DW-1:0] i_mltnd;
    logic [NREQ*DW-1:0] i_mlter;
    logic [NREQ-1:0]    o_gnt;
    logic [NREQ-1:0]    o_done;
    logic [2*DW-1:0]    o_product;
    logic               o_err;
    logic               o_busy;
    logic               o_ms_start;
    logic [DW-1:0]      o_ms_mltnd;
    logic [DW-1:0]      o_ms_mlter;
    logic [2*DW-1:0]    i_ms_product;
    logic               i_ms_ready;

    modport slave (
        input  i_req, i_mltnd, i_mlter, i_ms_product, i_ms_ready,
        output o_gnt, o_done, o_product, o_err, o_busy, o_ms_start, o_ms_mltnd, o_ms_mlter
    );

    modport master (
        output i_req, i_mltnd, i_mlter, i_ms_product, i_ms_ready,
        input  o_gnt, o_done, o_product, o_err, o_busy, o_ms_start, o_ms_mltnd, o_ms_mlter
    );
endinterface

// File: rtl/ms_arbiter.sv
// Round-robin sharing of one sequential multiplier among NREQ requesters.
// Latches the winner's operands, pulses start, returns the product or a timeout error.
module ms_arbiter #(
    parameter int DW      = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    ms_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    // IDLE arbitrate | START pulse ms_start | WAIT await ready or timeout | DONE report
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [DW-1:0]   mltnd_q, mltnd_d;
    logic [DW-1:0]   mlter_q, mlter_d;

    logic [NREQ-1:0] rot;
    logic            found;
    logic [PW-1:0]   pick;
    logic [DW-1:0]   a_sel, b_sel;

    // Rotate so bit 0 is the requester at the pointer; first set bit wins.
    always_comb begin
        rot   = NREQ'({bus.i_req, bus.i_req} >> ptr_q);
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                a_sel = bus.i_mltnd[i*DW +: DW];
                b_sel = bus.i_mlter[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        prod_d  = prod_q;
        mltnd_d = mltnd_q;
        mlter_d = mlter_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_START;
                    sel_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    mltnd_d     = a_sel;
                    mlter_d     = b_sel;
                    start_d     = 1'b1;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // The first WAIT cycle may still see ready from the previous operation.
                if (cnt_q != '0 && bus.i_ms_ready) begin
                    prod_d  = bus.i_ms_product;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            prod_q  <= '0;
            mltnd_q <= '0;
            mlter_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            prod_q  <= prod_d;
            mltnd_q <= mltnd_d;
            mlter_q <= mlter_d;
        end
    end

    assign bus.o_gnt      = gnt_q;
    assign bus.o_done     = done_q;
    assign bus.o_err      = err_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_ms_start = start_q;
    assign bus.o_product  = prod_q;
    assign bus.o_ms_mltnd = mltnd_q;
    assign bus.o_ms_mlter = mlter_q;

endmodule
